// File: rtl/aclk_pkg.sv
// Shared definitions for the 4x3 keypad encoder: FSM states, key-map
// positions and small decode helpers.
package aclk_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_RELEASE
    } state_t;

    // First column driven after reset; rotation is 001 -> 010 -> 100.
    localparam logic [2:0] COL_FIRST = 3'b001;

    // Non-digit keys on the bottom row.
    localparam logic [1:0] STAR_ROW = 2'd3;
    localparam logic [1:0] STAR_COL = 2'd0;
    localparam logic [1:0] HASH_ROW = 2'd3;
    localparam logic [1:0] HASH_COL = 2'd2;

    // BCD code of a digit key; the only digit on the bottom row is 0.
    function automatic logic [3:0] digit_code(input logic [1:0] row, input logic [1:0] col);
        if (row == 2'd3) begin
            return 4'd0;
        end
        return ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    endfunction

    // True when exactly one row line is active.
    function automatic logic row_single(input logic [3:0] rows);
        return (rows != 4'b0000) && ((rows & (rows - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] rows);
        case (rows)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] row_onehot(input logic [1:0] row);
        return 4'b0001 << row;
    endfunction

    function automatic logic [1:0] col_index(input logic [2:0] cols);
        case (cols)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/aclk_sync2.sv
// Two-flop synchronizer bringing the asynchronous keypad rows into the
// clock domain.
module aclk_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Shift raw inputs through two flops before anything consumes them.
    // NOTE: non-blocking assignments keep the two stages as distinct flops;
    // blocking here would collapse them into a single stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aclk_keypad_enc.sv
// 4x3 keypad scanner and encoder: rotates the column drive, debounces a
// single-key press, emits one pulse per press (shift with BCD key for
// digits, star or hash otherwise) and waits for a debounced release.
module aclk_keypad_enc
    import aclk_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [2:0] scan_col,
    output logic [3:0] key,
    output logic       shift,
    output logic       star,
    output logic       hash
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    // The count holds at most DEBOUNCE-1; the final matching sample
    // triggers the transition instead of being stored, so it never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    state_t           state;
    logic [3:0]       rs;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lat_row;
    logic [1:0]       lat_col;
    logic             sample;
    logic             go_emit;
    logic [1:0]       hit_row;
    logic [1:0]       hit_col;
    logic [2:0]       next_col;

    aclk_sync2 #(.WIDTH(4)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (row_in),
        .q     (rs)
    );

    assign sample   = (div_cnt == DIV_LAST);
    assign next_col = {scan_col[1:0], scan_col[2]};

    // Free-running dwell timer; a sample is taken on its last count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (sample) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Decide whether this sample completes a press, and which key it is.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        go_emit = 1'b0;
        hit_row = lat_row;
        hit_col = lat_col;
        if (state == ST_SCAN) begin
            hit_row = row_index(rs);
            hit_col = col_index(scan_col);
        end
        if (sample) begin
            if (state == ST_SCAN) begin
                go_emit = row_single(rs) && (DEBOUNCE <= 1);
            end else if (state == ST_DEBOUNCE) begin
                go_emit = (rs == row_onehot(lat_row)) && (cnt == CNT_LAST);
            end
        end
    end

    // Scan / debounce / emit / release sequencing with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_SCAN;
            scan_col <= COL_FIRST;
            cnt      <= '0;
            lat_row  <= '0;
            lat_col  <= '0;
            key      <= '0;
            shift    <= 1'b0;
            star     <= 1'b0;
            hash     <= 1'b0;
        end else begin
            shift <= 1'b0;
            star  <= 1'b0;
            hash  <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (sample) begin
                        if (row_single(rs)) begin
                            lat_row <= row_index(rs);
                            lat_col <= col_index(scan_col);
                            cnt     <= CNT_W'(1);
                            state   <= go_emit ? ST_EMIT : ST_DEBOUNCE;
                        end else begin
                            scan_col <= next_col;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (sample) begin
                        if (rs == row_onehot(lat_row)) begin
                            if (go_emit) begin
                                state <= ST_EMIT;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state    <= ST_SCAN;
                            scan_col <= next_col;
                        end
                    end
                end
                ST_EMIT: begin
                    cnt   <= '0;
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (sample) begin
                        if (rs != 4'b0000) begin
                            cnt <= '0;
                        end else if (cnt == CNT_LAST) begin
                            cnt      <= '0;
                            state    <= ST_SCAN;
                            scan_col <= next_col;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_SCAN;
                end
            endcase

            // Pulses are set on entry so they are high exactly during EMIT.
            if (go_emit) begin
                if (hit_row == STAR_ROW && hit_col == STAR_COL) begin
                    star <= 1'b1;
                end else if (hit_row == HASH_ROW && hit_col == HASH_COL) begin
                    hash <= 1'b1;
                end else begin
                    shift <= 1'b1;
                    key   <= digit_code(hit_row, hit_col);
                end
            end
        end
    end

endmodule

// File: tb/tb_aclk_keypad_enc.sv
// Directed testbench for aclk_keypad_enc with a behavioural keypad matrix
// and a downstream key shift register.
module tb_aclk_keypad_enc;
    import aclk_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row_in;
    logic [2:0]  scan_col;
    logic [3:0]  key;
    logic        shift;
    logic        star;
    logic        hash;

    // Pressed keys, bit index row*3+col.
    logic [11:0] press_mask = '0;

    int tests  = 0;
    int failed = 0;

    int shift_n = 0;
    int star_n  = 0;
    int hash_n  = 0;
    int multi_n = 0;
    logic [3:0]  key_log[$];
    logic [15:0] key_reg = '0;

    aclk_keypad_enc #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .row_in   (row_in),
        .scan_col (scan_col),
        .key      (key),
        .shift    (shift),
        .star     (star),
        .hash     (hash)
    );

    always #5 clock = ~clock;

    // Keypad matrix: a closed key connects its row to its driven column.
    always_comb begin
        row_in = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (press_mask[r*3+c] && scan_col[c]) begin
                    row_in[r] = 1'b1;
                end
            end
        end
    end

    // Pulse monitor and downstream key register.
    always @(negedge clock) begin
        if (shift) begin
            shift_n <= shift_n + 1;
            key_log.push_back(key);
            key_reg <= {key_reg[11:0], key};
        end
        if (star) star_n <= star_n + 1;
        if (hash) hash_n <= hash_n + 1;
        if (int'(shift) + int'(star) + int'(hash) > 1) multi_n <= multi_n + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic press(input int r, input int c);
        press_mask = '0;
        press_mask[r*3+c] = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        press_mask = '0;
        tick(3);
        tests++; if (scan_col !== 3'b001) begin failed++; $display("FAIL reset_scan_col: got %b expected 001", scan_col); end
        tests++; if (key !== 4'd0) begin failed++; $display("FAIL reset_key: got %0d expected 0", key); end
        tests++; if (shift !== 1'b0) begin failed++; $display("FAIL reset_shift: got %b expected 0", shift); end
        tests++; if (star !== 1'b0) begin failed++; $display("FAIL reset_star: got %b expected 0", star); end
        tests++; if (hash !== 1'b0) begin failed++; $display("FAIL reset_hash: got %b expected 0", hash); end
        tests++; if (dut.state !== ST_SCAN) begin failed++; $display("FAIL reset_state: got %0d expected %0d", dut.state, ST_SCAN); end
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_long_hold();
        int s0, t0, h0;
        s0 = shift_n; t0 = star_n; h0 = hash_n;
        press(1, 1);
        tick(200);
        press_mask = '0;
        tick(40);
        tests++; if (shift_n - s0 != 1) begin failed++; $display("FAIL hold_shift_count: got %0d expected 1", shift_n - s0); end
        tests++; if (key !== 4'd5) begin failed++; $display("FAIL hold_key: got %0d expected 5", key); end
        tests++; if (star_n - t0 != 0) begin failed++; $display("FAIL hold_star_count: got %0d expected 0", star_n - t0); end
        tests++; if (hash_n - h0 != 0) begin failed++; $display("FAIL hold_hash_count: got %0d expected 0", hash_n - h0); end
    endtask

    task automatic test_sequence();
        int rows[4];
        int cols[4];
        logic [3:0] exp_keys[4];
        int s0;
        rows = '{0, 1, 0, 0};
        cols = '{0, 2, 1, 0};
        exp_keys = '{4'd1, 4'd6, 4'd2, 4'd1};
        s0 = shift_n;
        key_log.delete();
        for (int i = 0; i < 4; i++) begin
            press(rows[i], cols[i]);
            tick(60);
            press_mask = '0;
            tick(60);
        end
        tests++; if (shift_n - s0 != 4) begin failed++; $display("FAIL seq_shift_count: got %0d expected 4", shift_n - s0); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (key_log.size() <= i) begin
                failed++; $display("FAIL seq_key%0d: got none expected %0d", i, exp_keys[i]);
            end else if (key_log[i] !== exp_keys[i]) begin
                failed++; $display("FAIL seq_key%0d: got %0d expected %0d", i, key_log[i], exp_keys[i]);
            end
        end
        tests++; if (key_reg !== 16'h1621) begin failed++; $display("FAIL seq_key_register: got %h expected 1621", key_reg); end
    endtask

    task automatic test_glitch();
        int s0, t0, h0;
        int n;
        s0 = shift_n; t0 = star_n; h0 = hash_n;
        n = 0;
        while (scan_col === 3'b001 && n < 50) begin tick(1); n++; end
        while (scan_col !== 3'b001 && n < 100) begin tick(1); n++; end
        tests++; if (n >= 100) begin failed++; $display("FAIL glitch_col0_wait: got timeout expected col0"); end
        press(0, 0);
        tick(4);
        press_mask = '0;
        tick(30);
        tests++; if ((shift_n - s0) + (star_n - t0) + (hash_n - h0) != 0) begin
            failed++; $display("FAIL glitch_no_pulse: got %0d pulses expected 0", (shift_n - s0) + (star_n - t0) + (hash_n - h0));
        end
        tests++; if (dut.state !== ST_SCAN) begin failed++; $display("FAIL glitch_state: got %0d expected %0d", dut.state, ST_SCAN); end
    endtask

    task automatic test_multi_and_specials();
        int s0, t0, h0;
        s0 = shift_n; t0 = star_n; h0 = hash_n;
        press_mask = '0;
        press_mask[0*3+1] = 1'b1;
        press_mask[2*3+1] = 1'b1;
        tick(100);
        press_mask = '0;
        tick(40);
        tests++; if ((shift_n - s0) + (star_n - t0) + (hash_n - h0) != 0) begin
            failed++; $display("FAIL multi_no_pulse: got %0d pulses expected 0", (shift_n - s0) + (star_n - t0) + (hash_n - h0));
        end
        press(3, 0);
        tick(60);
        press_mask = '0;
        tick(60);
        tests++; if (star_n - t0 != 1 || hash_n - h0 != 0) begin
            failed++; $display("FAIL star_pulse: got star %0d hash %0d expected star 1 hash 0", star_n - t0, hash_n - h0);
        end
        press(3, 2);
        tick(60);
        press_mask = '0;
        tick(60);
        tests++; if (hash_n - h0 != 1 || star_n - t0 != 1) begin
            failed++; $display("FAIL hash_pulse: got hash %0d star %0d expected hash 1 star 1", hash_n - h0, star_n - t0);
        end
        tests++; if (shift_n - s0 != 0) begin failed++; $display("FAIL specials_no_shift: got %0d expected 0", shift_n - s0); end
        tests++; if (key !== 4'd1) begin failed++; $display("FAIL specials_key_held: got %0d expected 1", key); end
    endtask

    task automatic test_reset_debounce();
        int s0;
        int n;
        s0 = shift_n;
        press(2, 2);
        n = 0;
        while (!(dut.state === ST_DEBOUNCE && int'(dut.cnt) == 2) && n < 100) begin tick(1); n++; end
        tests++; if (n >= 100) begin failed++; $display("FAIL rst_db_wait: got timeout expected DEBOUNCE count 2"); end
        reset = 1'b0;
        #1;
        tests++; if (scan_col !== 3'b001) begin failed++; $display("FAIL rst_db_scan_col: got %b expected 001", scan_col); end
        tests++; if (key !== 4'd0) begin failed++; $display("FAIL rst_db_key: got %0d expected 0", key); end
        tests++; if (dut.state !== ST_SCAN) begin failed++; $display("FAIL rst_db_state: got %0d expected %0d", dut.state, ST_SCAN); end
        press_mask = '0;
        tick(2);
        reset = 1'b1;
        tick(40);
        tests++; if (shift_n - s0 != 0) begin failed++; $display("FAIL rst_db_no_pulse: got %0d expected 0", shift_n - s0); end
    endtask

    task automatic test_release_bounce();
        int s0;
        int n;
        s0 = shift_n;
        press(1, 0);
        n = 0;
        while (shift_n == s0 && n < 100) begin tick(1); n++; end
        tests++; if (n >= 100) begin failed++; $display("FAIL bounce_first_wait: got timeout expected shift"); end
        tick(2);
        press_mask = '0;
        tick(4);
        press(1, 0);
        tick(60);
        tests++; if (shift_n - s0 != 1) begin failed++; $display("FAIL bounce_repress: got %0d pulses expected 1", shift_n - s0); end
        press_mask = '0;
        tick(60);
        tests++; if (shift_n - s0 != 1) begin failed++; $display("FAIL bounce_release: got %0d pulses expected 1", shift_n - s0); end
        press(1, 0);
        tick(60);
        press_mask = '0;
        tick(40);
        tests++; if (shift_n - s0 != 2) begin failed++; $display("FAIL bounce_new_press: got %0d pulses expected 2", shift_n - s0); end
        tests++; if (key !== 4'd4) begin failed++; $display("FAIL bounce_key: got %0d expected 4", key); end
    endtask

    initial begin
        test_reset();
        test_long_hold();
        test_sequence();
        test_glitch();
        test_multi_and_specials();
        test_reset_debounce();
        test_release_bounce();
        tests++; if (multi_n != 0) begin failed++; $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", multi_n); end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
